mc_ctrl_fsm: RTL and testbench

- Multicycle MIPS main control unit; sequences the write-enabled datapath registers (IR, PC, register file) and memory.
- Drives the IR load enable (IRWrite) and all datapath mux selects.
- Decodes the opcode latched in the IR and runs instructions through fetch/decode/execute/memory/writeback states.
- Holds fetch and memory states while memory is busy (mem_ready handshake); counts retired instructions.

---
 rtl/mc_ctrl_pkg.sv | 89 ++++++++
 rtl/mc_ctrl_outdec.sv | 82 ++++++++
 rtl/mc_ctrl_fsm.sv | 120 ++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS main control unit.
// Holds the FSM state encoding, the opcodes the controller decodes, the
// datapath mux-select encodings, the bundled control word driven by the
// output decoder, and small opcode-classification helpers.
package mc_ctrl_pkg;

  // Controller states. Codes 12..15 are unused and steer back to FETCH.
  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_R_EXEC   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_I_EXEC   = 4'd10,
    ST_I_WB     = 4'd11
  } state_e;

  // IR[31:26] values understood by the controller.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALU B-operand select.
  typedef enum logic [1:0] {
    SRCB_B       = 2'd0,
    SRCB_FOUR    = 2'd1,
    SRCB_IMM     = 2'd2,
    SRCB_IMM_SH2 = 2'd3
  } alusrcb_e;

  // ALU operation class handed to the ALU control decoder.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_e;

  // Next-PC select.
  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pcsrc_e;

  // Every datapath control produced for one state.
  typedef struct packed {
    logic     irwrite;
    logic     pcwrite;
    logic     pcwritecond;
    logic     iord;
    logic     memread;
    logic     memwrite;
    logic     memtoreg;
    logic     regdst;
    logic     regwrite;
    logic     alusrca;
    alusrcb_e alusrcb;
    aluop_e   aluop;
    pcsrc_e   pcsource;
  } ctrl_t;

  // First state after DECODE for a given opcode; FETCH for unsupported ones.
  function automatic state_e dispatch_state(input logic [5:0] op);
    state_e s;
    case (op)
      OP_LW, OP_SW: s = ST_MEM_ADDR;
      OP_RTYPE:     s = ST_R_EXEC;
      OP_BEQ:       s = ST_BRANCH;
      OP_J:         s = ST_JUMP;
      OP_ADDI:      s = ST_I_EXEC;
      default:      s = ST_FETCH;
    endcase
    return s;
  endfunction

  function automatic logic opcode_supported(input logic [5:0] op);
    return (op == OP_LW)  || (op == OP_SW)  || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_J)   || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// State-to-control decode for the multicycle MIPS controller.
// Purely combinational. Every control is a function of the current state,
// except IRWrite/PCWrite in FETCH, which follow the memory handshake so the
// IR and PC only load on the cycle the instruction word is actually valid.
//
// Ports:
//   state_i     current controller state
//   mem_ready_i memory completes the current access this cycle
//   ctrl_o      bundled datapath controls
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o          = '0;
    ctrl_o.alusrcb  = SRCB_B;
    ctrl_o.aluop    = ALUOP_ADD;
    ctrl_o.pcsource = PCSRC_ALU;

    case (state_i)
      ST_FETCH: begin
        // PC + 4 computed on the ALU while the instruction is read.
        ctrl_o.memread = 1'b1;
        ctrl_o.alusrcb = SRCB_FOUR;
        ctrl_o.irwrite = mem_ready_i;
        ctrl_o.pcwrite = mem_ready_i;
      end
      ST_DECODE: begin
        // Speculative branch target (PC + imm<<2) parked in ALUOut.
        ctrl_o.alusrcb = SRCB_IMM_SH2;
      end
      ST_MEM_ADDR: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
      end
      ST_MEM_RD: begin
        ctrl_o.memread = 1'b1;
        ctrl_o.iord    = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.memtoreg = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl_o.memwrite = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      ST_R_EXEC: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        ctrl_o.regwrite = 1'b1;
        ctrl_o.regdst   = 1'b1;
      end
      ST_BRANCH: begin
        // Datapath qualifies pcwritecond with the ALU zero flag.
        ctrl_o.alusrca     = 1'b1;
        ctrl_o.aluop       = ALUOP_SUB;
        ctrl_o.pcwritecond = 1'b1;
        ctrl_o.pcsource    = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl_o.pcwrite  = 1'b1;
        ctrl_o.pcsource = PCSRC_JUMP;
      end
      ST_I_EXEC: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
      end
      ST_I_WB: begin
        ctrl_o.regwrite = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main control unit.
// Sequences fetch/decode/execute/memory/writeback, stalls FETCH, MEM_RD and
// MEM_WR on the memory handshake, flags unsupported opcodes and counts
// retired instructions.
//
// Parameters:
//   CNT_W        width of the retired-instruction counter (wraps)
// Ports:
//   clk, reset   clock; asynchronous active-low reset
//   opcode       IR[31:26], sampled only in DECODE and MEM_ADDR
//   mem_ready    memory finishes the current read/write this cycle
//   zero         ALU zero flag (consumed by the datapath through PCWriteCond)
//   IRWrite .. PCSource   datapath enables and mux selects
//   state        current state encoding (debug)
//   illegal      one-cycle pulse when DECODE sees an unsupported opcode
//   instr_cnt    retired instruction count
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  input  logic             zero,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retire;
  ctrl_t            ctrl;

  // Branch resolution is done in the datapath (PCWriteCond & zero); the flag
  // is kept on this port list only so the block stays pin-compatible.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = ST_FETCH;
    retire  = 1'b0;
    illegal = 1'b0;

    case (state_q)
      ST_FETCH:    state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        state_d = dispatch_state(opcode);
        illegal = !opcode_supported(opcode);
      end
      ST_MEM_ADDR: state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   state_d = mem_ready ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WB:   retire  = 1'b1;
      ST_MEM_WR: begin
        // A store retires only on the cycle memory accepts it.
        state_d = mem_ready ? ST_FETCH : ST_MEM_WR;
        retire  = mem_ready;
      end
      ST_R_EXEC:   state_d = ST_R_WB;
      ST_R_WB:     retire  = 1'b1;
      ST_BRANCH:   retire  = 1'b1;
      ST_JUMP:     retire  = 1'b1;
      ST_I_EXEC:   state_d = ST_I_WB;
      ST_I_WB:     retire  = 1'b1;
      default:     state_d = ST_FETCH;
    endcase

    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Holding mem_ready off during reset keeps the IR/PC load enables low
  // while the rest of the machine is being cleared.
  mc_ctrl_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready & reset),
    .ctrl_o      (ctrl)
  );

  assign IRWrite     = ctrl.irwrite;
  assign PCWrite     = ctrl.pcwrite;
  assign PCWriteCond = ctrl.pcwritecond;
  assign IorD        = ctrl.iord;
  assign MemRead     = ctrl.memread;
  assign MemWrite    = ctrl.memwrite;
  assign MemtoReg    = ctrl.memtoreg;
  assign RegDst      = ctrl.regdst;
  assign RegWrite    = ctrl.regwrite;
  assign ALUSrcA     = ctrl.alusrca;
  assign ALUSrcB     = ctrl.alusrcb;
  assign ALUOp       = ctrl.aluop;
  assign PCSource    = ctrl.pcsource;
  assign state       = state_q;
  assign instr_cnt   = cnt_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
module tb_mc_ctrl_fsm;

  localparam logic [5:0] T_R    = 6'h00;
  localparam logic [5:0] T_J    = 6'h02;
  localparam logic [5:0] T_BEQ  = 6'h04;
  localparam logic [5:0] T_ADDI = 6'h08;
  localparam logic [5:0] T_LW   = 6'h23;
  localparam logic [5:0] T_SW   = 6'h2B;
  localparam logic [5:0] T_BAD  = 6'h3F;

  // LW, SW, R, BEQ, J, ADDI with memory always ready
  localparam int TR_ST [23] = '{0,1,2,3,4, 0,1,2,5, 0,1,6,7, 0,1,8, 0,1,9, 0,1,10,11};
  localparam logic [5:0] TR_OP [23] = '{T_LW,T_LW,T_LW,T_LW,T_LW, T_SW,T_SW,T_SW,T_SW,
                                        T_R,T_R,T_R,T_R, T_BEQ,T_BEQ,T_BEQ, T_J,T_J,T_J,
                                        T_ADDI,T_ADDI,T_ADDI,T_ADDI};
  // LW stalled 3 in FETCH and 2 in MEM_RD, then SW stalled 1 in MEM_WR
  localparam int MW_ST [15] = '{0,0,0,0,1,2,3,3,3,4, 0,1,2,5,5};
  localparam int MW_MR [15] = '{0,0,0,1,0,0,0,0,1,0, 1,0,0,0,1};
  // J, then an unsupported opcode
  localparam int IL_ST [6] = '{0,1,9,0,1,0};
  localparam int IL_MR [6] = '{1,1,1,1,1,0};
  localparam logic [5:0] IL_OP [6] = '{T_J,T_J,T_J,T_BAD,T_BAD,T_BAD};
  // BEQ taken, then BEQ not taken
  localparam int BR_ST [7] = '{0,1,8,0,1,8,0};
  localparam int BR_Z  [7] = '{1,1,1,0,0,0,0};
  localparam int BR_MR [7] = '{1,1,1,1,1,1,0};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic        zero = 1'b0;

  logic        IRWrite, PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, illegal;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state;
  logic [31:0] instr_cnt;

  logic        unused4_irw, unused4_pcw, unused4_pcc, unused4_iord, unused4_mr, unused4_mw;
  logic        unused4_m2r, unused4_rd, unused4_rw, unused4_sa, unused4_ill;
  logic [1:0]  unused4_sb, unused4_op, unused4_ps;
  logic [3:0]  unused4_st;
  logic [3:0]  w4_cnt;

  logic [13:0] ctrl_obs;
  assign ctrl_obs = {MemRead, MemWrite, IorD, MemtoReg, RegDst, RegWrite,
                     ALUSrcA, ALUSrcB, ALUOp, PCSource, PCWriteCond};

  typedef struct packed {
    logic [3:0]  st;
    logic        irw;
    logic        pcw;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  mc_ctrl_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .state(state), .illegal(illegal), .instr_cnt(instr_cnt)
  );

  mc_ctrl_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready), .zero(zero),
    .IRWrite(unused4_irw), .PCWrite(unused4_pcw), .PCWriteCond(unused4_pcc),
    .IorD(unused4_iord), .MemRead(unused4_mr), .MemWrite(unused4_mw),
    .MemtoReg(unused4_m2r), .RegDst(unused4_rd), .RegWrite(unused4_rw),
    .ALUSrcA(unused4_sa), .ALUSrcB(unused4_sb), .ALUOp(unused4_op),
    .PCSource(unused4_ps), .state(unused4_st), .illegal(unused4_ill), .instr_cnt(w4_cnt)
  );

  always #5 clk = ~clk;

  // Expected Moore controls per state: {care-mask, value}, bit order as ctrl_obs.
  // Enables (MemRead, MemWrite, RegWrite, PCWriteCond) are always checked.
  function automatic logic [27:0] spec_ctrl(input logic [3:0] s);
    logic [13:0] m, v;
    m = 14'b11_0001_0000_0001;
    v = '0;
    case (s)
      4'd0:  begin v[13] = 1'b1; m[11] = 1'b1; m[7:1] = '1; v[6:5] = 2'd1; end
      4'd1:  begin m[7:3] = '1; v[6:5] = 2'd3; end
      4'd2:  begin m[7:3] = '1; v[7] = 1'b1; v[6:5] = 2'd2; end
      4'd3:  begin v[13] = 1'b1; m[11] = 1'b1; v[11] = 1'b1; end
      4'd4:  begin v[8] = 1'b1; m[10:9] = '1; v[10] = 1'b1; end
      4'd5:  begin v[12] = 1'b1; m[11] = 1'b1; v[11] = 1'b1; end
      4'd6:  begin m[7:3] = '1; v[7] = 1'b1; v[4:3] = 2'd2; end
      4'd7:  begin v[8] = 1'b1; m[10:9] = '1; v[9] = 1'b1; end
      4'd8:  begin m[7:1] = '1; v[7] = 1'b1; v[4:3] = 2'd1; v[2:1] = 2'd1; v[0] = 1'b1; end
      4'd9:  begin m[2:1] = '1; v[2:1] = 2'd2; end
      4'd10: begin m[7:3] = '1; v[7] = 1'b1; v[6:5] = 2'd2; end
      4'd11: begin v[8] = 1'b1; m[10:9] = '1; end
      default: ;
    endcase
    return {m, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    opcode    = '0;
    zero      = 1'b0;
    reset     = 1'b0;
    #2;
    reset     = 1'b1;
  endtask

  task automatic test_reset();
    exp_t        e, got;
    logic [27:0] mv;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({state, instr_cnt, w4_cnt, RegWrite, MemRead, ALUSrcB, IRWrite, PCWrite} !==
        {4'd0, 32'd0, 4'd0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0})
      $display("FAIL reset_values: got st=%0d cnt=%0d cnt4=%0d rw=%b mr=%b srcb=%0d irw=%b pcw=%b, want 0 0 0 0 1 1 0 0",
               state, instr_cnt, w4_cnt, RegWrite, MemRead, ALUSrcB, IRWrite, PCWrite);
    else n_pass++;
    reset = 1'b1;
    // R-type up to R_WB, then abort with reset
    for (int k = 0; k < 4; k++) begin
      opcode = T_R; mem_ready = 1'b1;
      e.st = (k == 0) ? 4'd0 : (k == 1) ? 4'd1 : (k == 2) ? 4'd6 : 4'd7;
      e.irw = (k == 0); e.pcw = (k == 0); e.ill = 1'b0; e.cnt = 32'd0;
      sb.push_back(e);
      #1;
      got = sb.pop_front();
      mv  = spec_ctrl(got.st);
      n_checks++;
      if ({state, IRWrite, PCWrite, illegal, instr_cnt, ctrl_obs & mv[27:14]} !==
          {got.st, got.irw, got.pcw, got.ill, got.cnt, mv[13:0]})
        $display("FAIL reset_prefix cyc%0d: got st=%0d irw=%b pcw=%b ill=%b cnt=%0d ctrl=%b, want st=%0d irw=%b pcw=%b ill=%b cnt=%0d ctrl=%b mask=%b",
                 k, state, IRWrite, PCWrite, illegal, instr_cnt, ctrl_obs, got.st, got.irw, got.pcw, got.ill, got.cnt, mv[13:0], mv[27:14]);
      else n_pass++;
      if (k < 3) tick();
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({state, instr_cnt, RegWrite, MemRead} !== {4'd0, 32'd0, 1'b0, 1'b1})
      $display("FAIL reset_mid_rwb: got st=%0d cnt=%0d rw=%b mr=%b, want st=0 cnt=0 rw=0 mr=1",
               state, instr_cnt, RegWrite, MemRead);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({state, IRWrite} !== {4'd0, 1'b1})
      $display("FAIL reset_release_irw: got st=%0d irw=%b, want st=0 irw=1", state, IRWrite);
    else n_pass++;
    tick();
    n_checks++;
    if ({state, instr_cnt} !== {4'd1, 32'd0})
      $display("FAIL reset_first_fetch: got st=%0d cnt=%0d, want st=1 cnt=0", state, instr_cnt);
    else n_pass++;
  endtask

  task automatic test_trace();
    exp_t        e, got;
    logic [27:0] mv;
    logic [31:0] exp_cnt = 0;
    apply_reset();
    for (int k = 0; k < 23; k++) begin
      if (k > 0 && TR_ST[k] == 0 && TR_ST[k-1] > 1) exp_cnt++;
      opcode = TR_OP[k]; mem_ready = 1'b1; zero = 1'b0;
      e.st  = 4'(TR_ST[k]);
      e.irw = (TR_ST[k] == 0);
      e.pcw = (TR_ST[k] == 0) || (TR_ST[k] == 9);
      e.ill = 1'b0;
      e.cnt = exp_cnt;
      sb.push_back(e);
      #1;
      got = sb.pop_front();
      mv  = spec_ctrl(got.st);
      n_checks++;
      if ({state, IRWrite, PCWrite, illegal, instr_cnt, ctrl_obs & mv[27:14]} !==
          {got.st, got.irw, got.pcw, got.ill, got.cnt, mv[13:0]})
        $display("FAIL trace cyc%0d: got st=%0d irw=%b pcw=%b ill=%b cnt=%0d ctrl=%b, want st=%0d irw=%b pcw=%b ill=%b cnt=%0d ctrl=%b mask=%b",
                 k, state, IRWrite, PCWrite, illegal, instr_cnt, ctrl_obs, got.st, got.irw, got.pcw, got.ill, got.cnt, mv[13:0], mv[27:14]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({state, instr_cnt} !== {4'd0, 32'd6})
      $display("FAIL trace_total: got st=%0d cnt=%0d, want st=0 cnt=6", state, instr_cnt);
    else n_pass++;
  endtask

  task automatic test_mem_wait();
    exp_t        e, got;
    logic [27:0] mv;
    logic [31:0] exp_cnt = 0;
    int unsigned irw_n = 0, rw_n = 0;
    apply_reset();
    for (int k = 0; k < 15; k++) begin
      if (k > 0 && MW_ST[k] == 0 && MW_ST[k-1] > 1) exp_cnt++;
      opcode = (k < 10) ? T_LW : T_SW; mem_ready = (MW_MR[k] != 0);
      e.st  = 4'(MW_ST[k]);
      e.irw = (MW_ST[k] == 0) && (MW_MR[k] != 0);
      e.pcw = e.irw;
      e.ill = 1'b0;
      e.cnt = exp_cnt;
      sb.push_back(e);
      #1;
      if (k < 10) begin
        irw_n += (IRWrite === 1'b1) ? 1 : 0;
        rw_n  += (RegWrite === 1'b1) ? 1 : 0;
      end
      got = sb.pop_front();
      mv  = spec_ctrl(got.st);
      n_checks++;
      if ({state, IRWrite, PCWrite, illegal, instr_cnt, ctrl_obs & mv[27:14]} !==
          {got.st, got.irw, got.pcw, got.ill, got.cnt, mv[13:0]})
        $display("FAIL mem_wait cyc%0d: got st=%0d irw=%b pcw=%b ill=%b cnt=%0d ctrl=%b, want st=%0d irw=%b pcw=%b ill=%b cnt=%0d ctrl=%b mask=%b",
                 k, state, IRWrite, PCWrite, illegal, instr_cnt, ctrl_obs, got.st, got.irw, got.pcw, got.ill, got.cnt, mv[13:0], mv[27:14]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (irw_n != 1) $display("FAIL lw_irwrite_pulses: got %0d, want 1", irw_n);
    else n_pass++;
    n_checks++;
    if (rw_n != 1) $display("FAIL lw_regwrite_cycles: got %0d, want 1", rw_n);
    else n_pass++;
    n_checks++;
    if ({state, instr_cnt} !== {4'd0, 32'd2})
      $display("FAIL mem_wait_total: got st=%0d cnt=%0d, want st=0 cnt=2", state, instr_cnt);
    else n_pass++;
  endtask

  task automatic test_illegal();
    exp_t        e, got;
    logic [27:0] mv;
    logic [31:0] exp_cnt = 0;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      if (k > 0 && IL_ST[k] == 0 && IL_ST[k-1] > 1) exp_cnt++;
      opcode = IL_OP[k]; mem_ready = (IL_MR[k] != 0);
      e.st  = 4'(IL_ST[k]);
      e.irw = (IL_ST[k] == 0) && (IL_MR[k] != 0);
      e.pcw = e.irw || (IL_ST[k] == 9);
      e.ill = (k == 4);
      e.cnt = exp_cnt;
      sb.push_back(e);
      #1;
      got = sb.pop_front();
      mv  = spec_ctrl(got.st);
      n_checks++;
      if ({state, IRWrite, PCWrite, illegal, instr_cnt, ctrl_obs & mv[27:14]} !==
          {got.st, got.irw, got.pcw, got.ill, got.cnt, mv[13:0]})
        $display("FAIL illegal cyc%0d: got st=%0d irw=%b pcw=%b ill=%b cnt=%0d ctrl=%b, want st=%0d irw=%b pcw=%b ill=%b cnt=%0d ctrl=%b mask=%b",
                 k, state, IRWrite, PCWrite, illegal, instr_cnt, ctrl_obs, got.st, got.irw, got.pcw, got.ill, got.cnt, mv[13:0], mv[27:14]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({state, instr_cnt, illegal} !== {4'd0, 32'd1, 1'b0})
      $display("FAIL illegal_after: got st=%0d cnt=%0d ill=%b, want st=0 cnt=1 ill=0", state, instr_cnt, illegal);
    else n_pass++;
  endtask

  task automatic test_branch();
    exp_t        e, got;
    logic [27:0] mv;
    logic [31:0] exp_cnt = 0;
    apply_reset();
    for (int k = 0; k < 7; k++) begin
      if (k > 0 && BR_ST[k] == 0 && BR_ST[k-1] > 1) exp_cnt++;
      opcode = T_BEQ; mem_ready = (BR_MR[k] != 0); zero = (BR_Z[k] != 0);
      e.st  = 4'(BR_ST[k]);
      e.irw = (BR_ST[k] == 0) && (BR_MR[k] != 0);
      e.pcw = e.irw;
      e.ill = 1'b0;
      e.cnt = exp_cnt;
      sb.push_back(e);
      #1;
      got = sb.pop_front();
      mv  = spec_ctrl(got.st);
      n_checks++;
      if ({state, IRWrite, PCWrite, illegal, instr_cnt, ctrl_obs & mv[27:14]} !==
          {got.st, got.irw, got.pcw, got.ill, got.cnt, mv[13:0]})
        $display("FAIL branch cyc%0d zero=%b: got st=%0d irw=%b pcw=%b ill=%b cnt=%0d ctrl=%b, want st=%0d irw=%b pcw=%b ill=%b cnt=%0d ctrl=%b mask=%b",
                 k, zero, state, IRWrite, PCWrite, illegal, instr_cnt, ctrl_obs, got.st, got.irw, got.pcw, got.ill, got.cnt, mv[13:0], mv[27:14]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({state, instr_cnt} !== {4'd0, 32'd2})
      $display("FAIL branch_total: got st=%0d cnt=%0d, want st=0 cnt=2", state, instr_cnt);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [3:0]  e4;
    logic [31:0] e32;
    apply_reset();
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 4; c++) begin
        opcode = T_ADDI; mem_ready = 1'b1;
        tick();
      end
      e4  = 4'((i + 1) % 16);
      e32 = 32'(i + 1);
      n_checks++;
      if ({w4_cnt, instr_cnt, state} !== {e4, e32, 4'd0})
        $display("FAIL wrap_addi%0d: got cnt4=%0d cnt32=%0d st=%0d, want cnt4=%0d cnt32=%0d st=0",
                 i + 1, w4_cnt, instr_cnt, state, e4, e32);
      else n_pass++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_trace();
    test_mem_wait();
    test_illegal();
    test_branch();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
